// File: rtl/tt_um_asiclab_example.sv
// TinyTapeout tile: 8-bit accumulator ALU plus 8-bit PWM generator driven by a free-running counter.
// Results appear one clock after the sampling edge; no backpressure, and ena=0 freezes all state.
module tt_um_asiclab_example (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_LOAD    = 3'b001,
    OP_ADD     = 3'b010,
    OP_SUB     = 3'b011,
    OP_AND     = 3'b100,
    OP_OR      = 3'b101,
    OP_XOR     = 3'b110,
    OP_SETDUTY = 3'b111
  } op_e;

  logic [7:0] acc;
  logic       c;
  logic [7:0] duty;
  logic [7:0] cnt;

  op_e        op;
  logic       exec;
  logic [7:0] b;
  logic       z;
  logic       n;
  logic       pwm;
  logic       unused_ok;

  assign op        = op_e'(uio_in[2:0]);
  assign exec      = uio_in[3];
  assign b         = ui_in;
  assign unused_ok = &{1'b0, uio_in[7:4]};

  // rst_n is active-high despite its name; it is the harness signal name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc  <= 8'h00;
      c    <= 1'b0;
      duty <= 8'h00;
      cnt  <= 8'h00;
    end else if (ena) begin
      cnt <= cnt + 8'd1;
      if (exec) begin
        case (op)
          OP_LOAD:    acc <= b;
          OP_ADD:     {c, acc} <= {1'b0, acc} + {1'b0, b};
          OP_SUB: begin
            acc <= acc - b;
            c   <= (acc < b);
          end
          OP_AND:     acc <= acc & b;
          OP_OR:      acc <= acc | b;
          OP_XOR:     acc <= acc ^ b;
          OP_SETDUTY: duty <= b;
          default:    ;
        endcase
      end
    end
  end

  // Flags and PWM come only from registers, so inputs never reach outputs combinationally.
  assign z   = (acc == 8'h00);
  assign n   = acc[7];
  assign pwm = (cnt < duty);

  assign uo_out  = acc;
  assign uio_out = {pwm, n, c, z, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_asiclab_example.sv
// Scoreboard bench for tt_um_asiclab_example: expected outputs queued at drive time, popped one edge later.
module tb_tt_um_asiclab_example;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, SETDUTY = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];

  logic [7:0] acc_m, duty_m, cnt_m;
  logic       c_m;
  logic [8:0] sum_m;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_asiclab_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model, queue its outputs, then compare after the edge.
  task automatic step(input logic rst, input logic en, input logic ex,
                      input logic [2:0] op, input logic [7:0] b);
    exp_t e;
    rst_n  = rst;
    ena    = en;
    ui_in  = b;
    uio_in = {4'($urandom_range(0, 15)), ex, op};
    if (rst) begin
      acc_m = 8'h00; c_m = 1'b0; duty_m = 8'h00; cnt_m = 8'h00;
    end else if (en) begin
      cnt_m = cnt_m + 8'd1;
      if (ex) begin
        case (op)
          LOAD:    acc_m = b;
          ADD: begin
            sum_m = {1'b0, acc_m} + {1'b0, b};
            acc_m = sum_m[7:0];
            c_m   = sum_m[8];
          end
          SUB: begin
            c_m   = (acc_m < b);
            acc_m = acc_m - b;
          end
          AND_:    acc_m = acc_m & b;
          OR_:     acc_m = acc_m | b;
          XOR_:    acc_m = acc_m ^ b;
          SETDUTY: duty_m = b;
          default: ;
        endcase
      end
    end
    e.uo  = acc_m;
    e.uio = {(cnt_m < duty_m), acc_m[7], c_m, (acc_m == 8'h00), 4'b0000};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check("uo_out", {8'h00, uo_out}, {8'h00, e.uo});
      check("uio_out", {8'h00, uio_out}, {8'h00, e.uio});
    end
    check("uio_oe", {8'h00, uio_oe}, 16'h00F0);
  endtask

  initial begin
    logic [7:0] save_uo, save_uio;
    int         hi;
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    acc_m = 8'h00; c_m = 1'b0; duty_m = 8'h00; cnt_m = 8'h00; sum_m = 9'h000;

    // Reset overrides an active LOAD
    repeat (2) begin
      step(1, 1, 1, LOAD, 8'h5A);
      check("rst_uo", {8'h00, uo_out}, 16'h0000);
      check("rst_uio", {8'h00, uio_out}, 16'h0010);
    end

    // LOAD/ADD carry
    step(0, 1, 1, LOAD, 8'hF0);
    step(0, 1, 1, ADD, 8'h20);
    check("add_carry_uo", {8'h00, uo_out}, 16'h0010);
    check("add_carry_czn", {13'h0, uio_out[5], uio_out[4], uio_out[6]}, 16'b100);
    step(0, 1, 1, ADD, 8'h01);
    check("add_nocarry_uo", {8'h00, uo_out}, 16'h0011);
    check("add_nocarry_c", {15'h0, uio_out[5]}, 16'h0);

    // SUB borrow and zero
    step(0, 1, 1, LOAD, 8'h05);
    step(0, 1, 1, SUB, 8'h06);
    check("sub_borrow_uo", {8'h00, uo_out}, 16'h00FF);
    check("sub_borrow_cn", {14'h0, uio_out[5], uio_out[6]}, 16'b11);
    step(0, 1, 1, LOAD, 8'h07);
    step(0, 1, 1, SUB, 8'h07);
    check("sub_zero_uo", {8'h00, uo_out}, 16'h0000);
    check("sub_zero_zc", {14'h0, uio_out[4], uio_out[5]}, 16'b10);

    // Logic ops with C=1 held across them
    step(0, 1, 1, LOAD, 8'hFF);
    step(0, 1, 1, ADD, 8'h01);
    step(0, 1, 1, LOAD, 8'hAA);
    step(0, 1, 1, AND_, 8'h0F);
    check("and_uo", {8'h00, uo_out}, 16'h000A);
    check("and_c", {15'h0, uio_out[5]}, 16'h1);
    step(0, 1, 1, OR_, 8'hF0);
    check("or_uo", {8'h00, uo_out}, 16'h00FA);
    check("or_c", {15'h0, uio_out[5]}, 16'h1);
    step(0, 1, 1, XOR_, 8'hFF);
    check("xor_uo", {8'h00, uo_out}, 16'h0005);
    check("xor_c", {15'h0, uio_out[5]}, 16'h1);
    step(0, 1, 1, NOP, 8'h33);
    step(0, 1, 0, ADD, 8'h33);
    check("nop_noexec_uo", {8'h00, uo_out}, 16'h0005);

    // PWM duty 0x40 over a full counter period
    step(0, 1, 1, SETDUTY, 8'h40);
    check("setduty_uo", {8'h00, uo_out}, 16'h0005);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0, NOP, 8'h00);
      if (uio_out[7] === 1'b1) hi++;
    end
    check("pwm_40_count", 16'(hi), 16'd64);
    step(0, 1, 1, SETDUTY, 8'h00);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0, NOP, 8'h00);
      if (uio_out[7] === 1'b1) hi++;
    end
    check("pwm_00_count", 16'(hi), 16'd0);

    // Enable gating: state frozen, PWM phase resumes
    step(0, 1, 1, SETDUTY, 8'h80);
    repeat (100) step(0, 1, 0, NOP, 8'h00);
    save_uo  = uo_out;
    save_uio = uio_out;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, LOAD, 8'h55);
      check("gate_uo", {8'h00, uo_out}, {8'h00, save_uo});
      check("gate_uio", {8'h00, uio_out}, {8'h00, save_uio});
    end
    repeat (40) step(0, 1, 0, NOP, 8'h00);

    // Mixed random traffic against the model
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));

    // Reset wins over ena=0
    step(0, 1, 1, LOAD, 8'h9C);
    step(1, 0, 1, LOAD, 8'h9C);
    check("rst_noena_uo", {8'h00, uo_out}, 16'h0000);
    check("rst_noena_uio", {8'h00, uio_out}, 16'h0010);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_asiclab_example.md
Name: tt_um_asiclab_example

Overview:
TinyTapeout user tile holding an 8-bit accumulator ALU and an 8-bit PWM generator.
- Operands arrive on ui_in; opcode and execute strobe arrive on uio_in[3:0].
- The accumulator drives uo_out; status flags and the PWM waveform drive uio_out[7:4].
- Sits directly under the TinyTapeout harness as the top-level user module.

Parameters:
none (all datapaths fixed at 8 bits)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-high reset; asserted when 1. Name kept per harness convention.
ena  input  1  tile enable; when 0 every register holds its value
ui_in  input  8  operand B
uo_out  output  8  accumulator value ACC
uio_in  input  8  [2:0] opcode OP, [3] EXEC strobe, [7:4] ignored
uio_out  output  8  [3:0]=0, [4]=Z, [5]=C, [6]=N, [7]=PWM
uio_oe  output  8  constant 8'hF0

Behaviour:
- State registers:
  - ACC[7:0], carry C, DUTY[7:0], free-running counter CNT[7:0].
- Reset (rst_n=1 at a rising edge):
  - ACC=0, C=0, DUTY=0, CNT=0.
  - Next-cycle outputs: uo_out=8'h00, uio_out=8'h10 (Z=1, PWM=0).
  - Reset overrides ena and EXEC.
- Hold: ena=0 and no reset → ACC, C, DUTY and CNT all hold; outputs stay static.
- CNT: increments by 1 every enabled cycle and wraps 8'hFF→8'h00.
- Execute: on an enabled edge with EXEC=1, apply OP with B=ui_in:
  - 000 NOP: no change.
  - 001 LOAD: ACC=B; C unchanged.
  - 010 ADD: {C,ACC}=ACC+B (9-bit sum).
  - 011 SUB: ACC=ACC-B mod 256; C=1 iff ACC<B (borrow).
  - 100 AND: ACC=ACC&B.
  - 101 OR: ACC=ACC|B.
  - 110 XOR: ACC=ACC^B.
  - 111 SETDUTY: DUTY=B; ACC and C unchanged.
- EXEC is level-sensitive: the operation repeats on every enabled edge while EXEC=1. No edge detection.
- C changes only on ADD and SUB.
- Latency: result appears on uo_out and the flags one clock after the sampling edge. There is no combinational path from ui_in/uio_in to any output.
- Flags:
  - Z = (ACC==0) and N = ACC[7]; both derived from the registered ACC.
  - C is a register.
- PWM = (CNT < DUTY), computed from registered CNT and DUTY:
  - DUTY=0 → PWM always 0.
  - DUTY=255 → PWM high 255 of every 256 cycles.
- uio_out[3:0] is driven 0; uio_oe is constant 8'hF0 in all states, including reset.
- Unused inputs (uio_in[7:4]) are ignored.

Test Plan:
- Reset: assert rst_n=1 for 2 cycles with EXEC=1 and OP=001 → uo_out=00, uio_out=8'h10, uio_oe=F0 throughout.
- LOAD/ADD carry: LOAD 8'hF0, then ADD 8'h20 → uo_out=8'h10, C=1, Z=0, N=0. Then ADD 8'h01 → uo_out=8'h11, C=0.
- SUB borrow and zero: LOAD 8'h05, then SUB 8'h06 → uo_out=8'hFF, C=1, N=1. Then LOAD 8'h07 and SUB 8'h07 → uo_out=00, Z=1, C=0.
- Logic ops: LOAD 8'hAA, then AND 8'h0F → 8'h0A; OR 8'hF0 → 8'hFA; XOR 8'hFF → 8'h05. C unchanged across all three.
- PWM: SETDUTY 8'h40 with ena=1, then count PWM over 256 consecutive cycles → exactly 64 high. SETDUTY 00 → PWM never high.
- Enable gating: with ena=0 and EXEC=1, OP=001, ui_in=8'h55 for 10 cycles → uo_out and PWM unchanged, and CNT frozen (PWM phase resumes where it stopped once ena=1).
